fir_sym_mac: RTL
================

# fir_sym_mac

Parametrised, time-multiplexed symmetric (linear-phase) FIR filter with a single pre-add/multiply/accumulate datapath. It is the generalised successor to the fixed 32-tap, fully parallel low-pass FIR in the FILTER/FIR tree, and sits between the sample-rate ADC front end and downstream decimation/DSP stages. One output sample is produced per accepted input sample after TAPS/2 MAC cycles, with round-half-up scaling and saturating output.

## Interface
- DW, 12, input/output sample width (signed)
- CW, 12, coefficient width (signed)
- TAPS, 32, filter length; even, ≥4; TAPS/2 unique coefficients
- OSHIFT, 11, arithmetic right shift applied to accumulator before saturation; ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample offered
- in_ready  out  1  block can accept a sample (high only in IDLE)
- din  in  DW  signed input sample
- out_valid  out  1  one-cycle pulse, dout/sat valid
- dout  out  DW  signed filtered sample, held until next out_valid
- sat  out  1  dout was clamped; updated with out_valid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS/2)  coefficient index k
- coef_wdata  in  CW  signed coefficient value

## Operation
- Delay line x[0..TAPS-1], DW bits each; coefficient file c[0..TAPS/2-1].
- y = sum over k=0..TAPS/2-1 of (x[k] + x[TAPS-1-k]) * c[k]; pre-add is DW+1 bits; product DW+1+CW bits; accumulator ACCW = DW+1+CW+clog2(TAPS/2) bits, no overflow possible.
- FSM states: IDLE, MAC, FIN.
  - IDLE: in_ready=1. On in_valid: x[0]<=din, x[i]<=x[i-1], acc<=0, k<=0, go to MAC.
  - MAC: acc += (x[k]+x[TAPS-1-k])*c[k]; k++; after k=TAPS/2-1 go to FIN.
  - FIN: r = (acc + 2^(OSHIFT-1)) >>> OSHIFT; if r > 2^(DW-1)-1, dout<=max and sat<=1; if r < -2^(DW-1), dout<=min and sat<=1; otherwise dout<=r[DW-1:0] and sat<=0. out_valid<=1, go to IDLE.
- in_valid outside IDLE is ignored; the source must hold it until in_ready.
- Coefficient writes are accepted only when in_ready=1; coef_we in MAC/FIN is dropped, so the coefficient set never changes mid-sample. Write and sample accept in the same IDLE cycle: the write lands first and is used for that sample.
- Reset (any state, including mid-MAC): state IDLE, k=0, acc=0, delay line cleared, dout=0, sat=0, out_valid=0, in_ready=1 after release; coefficients return to package defaults.

## Timing
- Accept edge E0. MAC edges are E1..E(TAPS/2). FIN edge E(TAPS/2+1) registers dout/sat/out_valid.
- Latency is TAPS/2+1 cycles from accept to out_valid high (17 at default).
- Maximum throughput is one sample per TAPS/2+2 cycles (18 at default). in_ready is high in the cycle out_valid is high.
- out_valid is high for exactly one cycle. dout and sat are stable otherwise.

## Configuration
- FIR_COEF_WR_EN defined: the coefficient file is registers, reset to the package default set, and writable through coef_*.
- FIR_COEF_WR_EN undefined: coefficients are the package constant set; coef_* inputs are ignored and may be tied low. TAPS must then equal the package default length (32). Elaboration fails otherwise.

## Structure
- Package fir_pkg: FIR_DEF_TAPS=32; default 16-entry low-pass coefficient array (35, 58, 103, 164, 245, 345, 463, 596, 741, 891, 1040, 1181, 1304, 1404, 1474, 1511); FSM state enum; ACCW helper function.
- One sub-module, fir_coef_bank: register/constant coefficient storage with the write gate and the FIR_COEF_WR_EN switch. The delay line, FSM and MAC stay in the top.

## Test plan
- Reset mid-MAC: assert rst at E5 → dout=0, sat=0, out_valid=0, in_ready=1. The next impulse output ignores pre-reset samples.
- Rounding: c[0]=1024, other coefficients 0. din=101 then zeros → first dout=51 (50.5 rounds up). din=100 → 50. After 31 further zero samples, the symmetric tap gives 51 again.
- Saturation: all c=2047, 32 samples of din=2047 → dout=2047, sat=1. 32 samples of din=-2048 → dout=-2048, sat=1.
- Handshake: in_valid held high for 5 samples → accepts exactly every 18 cycles. out_valid appears 17 cycles after each accept. in_ready is low during MAC/FIN.
- Coefficient gating: coef_we to c[0]=500 during MAC → ignored, and the current and next outputs use the old c[0]. The same write in IDLE coincident with accept → used for that sample.
- Defaults: with no writes, an impulse din=1000 → output sequence equals round(1000*c[k]/2048) per tap, symmetric across 32 outputs, sat=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the symmetric FIR: default tap count, default low-pass
// coefficient set, FSM state encoding and the accumulator width helper.
package fir_pkg;

  localparam int FIR_DEF_TAPS = 32;

  localparam int FIR_DEF_COEF [FIR_DEF_TAPS/2] = '{
    35, 58, 103, 164, 245, 345, 463, 596,
    741, 891, 1040, 1181, 1304, 1404, 1474, 1511
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FIN
  } fir_state_e;

  // Wide enough that TAPS/2 full-scale pre-add products can never overflow.
  function automatic int fir_accw(input int dw, input int cw, input int taps);
    return dw + 1 + cw + $clog2(taps / 2);
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample handshake, filtered output and coefficient write port of the
// symmetric FIR, bundled with master (source) and slave (filter) views.
interface fir_if #(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int TAPS = 32
);

  localparam int AW = $clog2(TAPS / 2);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] din;
  logic                 out_valid;
  logic signed [DW-1:0] dout;
  logic                 sat;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;

  modport master (
    output in_valid, din, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, dout, sat
  );

  modport slave (
    input  in_valid, din, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, dout, sat
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient storage for the symmetric FIR. With FIR_COEF_WR_EN defined it is a
// writable register file reset to the package set; otherwise it is that constant set.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int CW   = 12,
  parameter int TAPS = 32,
  localparam int AW  = $clog2(TAPS / 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic signed [CW-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [CW-1:0] rd_data
);

  localparam int NC = TAPS / 2;

`ifdef FIR_COEF_WR_EN

  logic signed [CW-1:0] coef [NC];

  // Taps beyond the package set (longer filters) start out as zero.
  function automatic logic signed [CW-1:0] def_coef(input int idx);
    return (idx < FIR_DEF_TAPS / 2) ? CW'(FIR_DEF_COEF[idx]) : '0;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) coef[i] <= def_coef(i);
    end else if (we && wr_en) begin
      coef[wr_addr] <= wr_data;
    end
  end

  assign rd_data = coef[rd_addr];

`else

  if (TAPS != FIR_DEF_TAPS) begin : g_taps_check
    $error("fir_coef_bank: fixed coefficient set requires TAPS == FIR_DEF_TAPS");
  end

  logic unused_write_port;
  assign unused_write_port = ^{clk, rst, we, wr_en, wr_addr, wr_data};

  assign rd_data = CW'(FIR_DEF_COEF[rd_addr]);

`endif

endmodule

// File: rtl/fir_sym_mac.sv
// Time-multiplexed symmetric FIR: one pre-add/multiply/accumulate per cycle, rounded,
// shifted and saturated output. Coefficient writes are enabled by FIR_COEF_WR_EN.
module fir_sym_mac
  import fir_pkg::*;
#(
  parameter int DW     = 12,
  parameter int CW     = 12,
  parameter int TAPS   = 32,
  parameter int OSHIFT = 11
) (
  input logic   clk,
  input logic   rst,
  fir_if.slave  bus
);

  localparam int NC   = TAPS / 2;
  localparam int KW   = $clog2(NC);
  localparam int XW   = $clog2(TAPS);
  localparam int PW   = DW + 1 + CW;
  localparam int ACCW = fir_accw(DW, CW, TAPS);

  localparam logic [KW-1:0]          K_LAST = KW'(NC - 1);
  localparam logic signed [ACCW-1:0] HALF   = ACCW'(1) << (OSHIFT - 1);
  localparam logic signed [ACCW-1:0] MAXV   = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV   = ~MAXV;

  fir_state_e state, state_next;

  logic [KW-1:0]          k;
  logic signed [DW-1:0]   x [TAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [CW-1:0]   coef;
  logic [XW-1:0]          near_idx;
  logic [XW-1:0]          far_idx;
  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] rounded;
  logic signed [ACCW-1:0] shifted;
  logic                   idle;
  logic                   accept;
  logic signed [DW-1:0]   dout_q;
  logic                   sat_q;
  logic                   out_valid_q;

  assign idle          = (state == IDLE);
  assign accept        = idle && bus.in_valid;
  assign bus.in_ready  = idle;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;

  // Writes are gated by idle, so the set is frozen while a sample is in flight.
  fir_coef_bank #(
    .CW   (CW),
    .TAPS (TAPS)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.coef_we),
    .wr_en   (idle),
    .wr_addr (bus.coef_addr),
    .wr_data (bus.coef_wdata),
    .rd_addr (k),
    .rd_data (coef)
  );

  assign near_idx = XW'(k);
  assign far_idx  = XW'(TAPS - 1) - XW'(k);
  assign pre      = (DW+1)'(x[near_idx]) + (DW+1)'(x[far_idx]);
  assign prod     = PW'(pre) * PW'(coef);
  assign rounded  = acc + HALF;
  assign shifted  = rounded >>> OSHIFT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (k == K_LAST) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delay line, MAC accumulator and the registered, saturated output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k           <= '0;
      acc         <= '0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x[0] <= bus.din;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          k   <= k + 1'b1;
        end
        FIN: begin
          out_valid_q <= 1'b1;
          k           <= '0;
          if (shifted > MAXV) begin
            dout_q <= MAXV[DW-1:0];
            sat_q  <= 1'b1;
          end else if (shifted < MINV) begin
            dout_q <= MINV[DW-1:0];
            sat_q  <= 1'b1;
          end else begin
            dout_q <= shifted[DW-1:0];
            sat_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
